me_pe_sad_cell: RTL and testbench

Parametrised motion-estimation processing element: a generalisation of the 4-slot, 2-source PE cell. It holds NUM_CB preloaded current-block pixels, forwards current pixels and reference pixels to neighbouring cells, and computes a registered absolute difference. It also adds an optional in-cell SAD accumulator that emits one sum every ACC_LEN valid comparisons. It sits in the ME PE array between the current-block loader and the SAD reduction tree.

---
 rtl/me_pkg.sv | 24 ++
 rtl/me_pe_sad_cell_if.sv | 54 +++++
 rtl/me_sad_acc.sv | 77 +++++++
 rtl/me_pe_sad_cell.sv | 112 +++++++++++
 tb/tb_me_pe_sad_cell.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// me_pkg: definitions shared by the motion-estimation PE array.
// The SAD reduction tree imports this package so that it sizes its inputs
// exactly as the PE cells size their outputs.
//   PIXEL_W_DEF  default pixel width
//   pixel_t      pixel type at the default width
//   sel_w()      select width for an n-way choice (minimum 1 bit)
//   acc_w()      SAD accumulator width; it cannot overflow over a window
package me_pkg;

  localparam int PIXEL_W_DEF = 8;

  typedef logic [PIXEL_W_DEF-1:0] pixel_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A window of len differences, each at most 2^pw - 1, sums to less than
  // (len+1) * 2^pw. That needs pw + clog2(len+1) bits.
  function automatic int acc_w(input int pw, input int len);
    return pw + $clog2(len + 1);
  endfunction

endpackage

// File: rtl/me_pe_sad_cell_if.sv
// me_pe_sad_cell_if: bundle of signals between the PE array control/neighbours
// and one me_pe_sad_cell.
//   master modport: drives slot writes, ref loads and compares; sees the outputs
//   slave modport : the PE cell itself
//
// Handshake semantics: the cell never back-pressures, so there is no ready.
// curr_wr_en, ref_shift_en and cmp_valid act in the cycle they are high.
// abs_valid and sad_valid are single-cycle qualifiers for abs_out and sad_out.
// The consumer must take the data in that cycle. The data outputs hold their
// last value while the qualifier is low.
interface me_pe_sad_cell_if
  import me_pkg::*;
#(
  parameter int PIXEL_W     = PIXEL_W_DEF,
  parameter int NUM_CB      = 4,
  parameter int NUM_REF_SRC = 2,
  parameter int ACC_LEN     = 16
);

  localparam int SEL_W  = sel_w(NUM_CB);
  localparam int RSEL_W = sel_w(NUM_REF_SRC);
  localparam int ACC_W  = acc_w(PIXEL_W, ACC_LEN);

  logic                           curr_wr_en;
  logic [SEL_W-1:0]               curr_sel;
  logic [PIXEL_W-1:0]             curr_in;
  logic [PIXEL_W-1:0]             curr_out;
  logic                           ref_shift_en;
  logic [RSEL_W-1:0]              ref_src_sel;
  logic [NUM_REF_SRC*PIXEL_W-1:0] ref_in;
  logic [PIXEL_W-1:0]             ref_out;
  logic                           cmp_valid;
  logic [SEL_W-1:0]               cmp_sel;
  logic                           sad_clear;
  logic [PIXEL_W-1:0]             abs_out;
  logic                           abs_valid;
  logic [ACC_W-1:0]               sad_out;
  logic                           sad_valid;

  modport master (
    output curr_wr_en, curr_sel, curr_in,
    output ref_shift_en, ref_src_sel, ref_in,
    output cmp_valid, cmp_sel, sad_clear,
    input  curr_out, ref_out, abs_out, abs_valid, sad_out, sad_valid
  );

  modport slave (
    input  curr_wr_en, curr_sel, curr_in,
    input  ref_shift_en, ref_src_sel, ref_in,
    input  cmp_valid, cmp_sel, sad_clear,
    output curr_out, ref_out, abs_out, abs_valid, sad_out, sad_valid
  );

endinterface

// File: rtl/me_sad_acc.sv
// me_sad_acc: windowed SAD accumulator (stage 2 of the PE cell).
// It sums ACC_LEN qualified absolute differences. It then emits the total on
// sad_o with a one-cycle sad_valid_o pulse and starts the next window at zero.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   abs_valid_i   abs_i qualifier (registered stage-1 output)
//   abs_i         absolute difference
//   clear_i       discard the partial window; a coincident abs_i starts the new one
//   sad_o         completed window sum, holds between windows
//   sad_valid_o   one-cycle pulse per completed window
// The top instantiates this module only when ME_PE_SAD_ACC_EN is defined.
module me_sad_acc
  import me_pkg::*;
#(
  parameter int PIXEL_W = PIXEL_W_DEF,
  parameter int ACC_LEN = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                abs_valid_i,
  input  logic [PIXEL_W-1:0]                  abs_i,
  input  logic                                clear_i,
  output logic [acc_w(PIXEL_W, ACC_LEN)-1:0]  sad_o,
  output logic                                sad_valid_o
);

  localparam int ACC_W = acc_w(PIXEL_W, ACC_LEN);
  localparam int CNT_W = sel_w(ACC_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  logic [ACC_W-1:0] acc_q, acc_d, acc_base, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [ACC_W-1:0] sad_q, sad_d;
  logic             sad_valid_q, sad_valid_d;

  // A clear replaces the running state with an empty window before the
  // current difference is applied. A clear that coincides with abs_valid
  // therefore counts that difference as the first of the new window.
  always_comb begin
    acc_base    = clear_i ? '0 : acc_q;
    cnt_base    = clear_i ? '0 : cnt_q;
    acc_sum     = acc_base + ACC_W'(abs_i);
    acc_d       = acc_base;
    cnt_d       = cnt_base;
    sad_d       = sad_q;
    sad_valid_d = 1'b0;
    if (abs_valid_i) begin
      if (cnt_base == CNT_LAST) begin
        sad_d       = acc_sum;
        sad_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
    end
  end

  assign sad_o       = sad_q;
  assign sad_valid_o = sad_valid_q;

endmodule

// File: rtl/me_pe_sad_cell.sv
// me_pe_sad_cell: motion-estimation processing element.
// The cell holds NUM_CB current-block pixels and forwards one of them
// downstream. It loads a reference pixel from one of NUM_REF_SRC neighbours
// and produces a registered |slot - ref|. It can also produce a windowed SAD.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   bus (slave)        curr_wr_en/curr_sel/curr_in -> slot write, curr_out = slot[curr_sel]
//                      ref_shift_en/ref_src_sel/ref_in -> ref_out register
//                      cmp_valid/cmp_sel -> abs_out/abs_valid one cycle later
//                      sad_clear -> sad_out/sad_valid (accumulator build only)
// Configuration macro ME_PE_SAD_ACC_EN: when it is defined, the me_sad_acc
// accumulator is present. Otherwise sad_out and sad_valid are tied to 0 and
// sad_clear is ignored.
module me_pe_sad_cell
  import me_pkg::*;
#(
  parameter int PIXEL_W     = PIXEL_W_DEF,
  parameter int NUM_CB      = 4,
  parameter int NUM_REF_SRC = 2,
  parameter int ACC_LEN     = 16
) (
  input logic              clk,
  input logic              rst_n,
  me_pe_sad_cell_if.slave  bus
);

  localparam int SEL_W  = sel_w(NUM_CB);
  localparam int RSEL_W = sel_w(NUM_REF_SRC);
  localparam int ACC_W  = acc_w(PIXEL_W, ACC_LEN);

  logic [PIXEL_W-1:0] slot_q [NUM_CB];
  logic [PIXEL_W-1:0] slot_d [NUM_CB];
  logic [PIXEL_W-1:0] ref_q, ref_d, ref_pick;
  logic [PIXEL_W-1:0] curr_pix, cmp_pix, abs_diff;
  logic [PIXEL_W-1:0] abs_q, abs_d;
  logic               abs_valid_q, abs_valid_d;

  // Selects that fall outside the populated range match no slot or source.
  // The muxes then yield 0, and a write to such a slot is dropped.
  always_comb begin
    curr_pix = '0;
    cmp_pix  = '0;
    for (int i = 0; i < NUM_CB; i++) begin
      slot_d[i] = slot_q[i];
      if (bus.curr_sel == SEL_W'(i)) curr_pix = slot_q[i];
      if (bus.cmp_sel == SEL_W'(i))  cmp_pix  = slot_q[i];
      if (bus.curr_wr_en && (bus.curr_sel == SEL_W'(i))) slot_d[i] = bus.curr_in;
    end
  end

  always_comb begin
    ref_pick = '0;
    for (int i = 0; i < NUM_REF_SRC; i++) begin
      if (bus.ref_src_sel == RSEL_W'(i)) ref_pick = bus.ref_in[i*PIXEL_W +: PIXEL_W];
    end
    ref_d = bus.ref_shift_en ? ref_pick : ref_q;
  end

  // The compare reads the registered slot and ref values. A write or ref
  // load in the same cycle therefore takes effect only for later compares.
  always_comb begin
    abs_diff    = (cmp_pix >= ref_q) ? (cmp_pix - ref_q) : (ref_q - cmp_pix);
    abs_d       = bus.cmp_valid ? abs_diff : abs_q;
    abs_valid_d = bus.cmp_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CB; i++) slot_q[i] <= '0;
      ref_q       <= '0;
      abs_q       <= '0;
      abs_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CB; i++) slot_q[i] <= slot_d[i];
      ref_q       <= ref_d;
      abs_q       <= abs_d;
      abs_valid_q <= abs_valid_d;
    end
  end

  assign bus.curr_out  = curr_pix;
  assign bus.ref_out   = ref_q;
  assign bus.abs_out   = abs_q;
  assign bus.abs_valid = abs_valid_q;

`ifdef ME_PE_SAD_ACC_EN
  logic [ACC_W-1:0] sad_w;
  logic             sad_valid_w;

  me_sad_acc #(
    .PIXEL_W (PIXEL_W),
    .ACC_LEN (ACC_LEN)
  ) u_sad_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .abs_valid_i (abs_valid_q),
    .abs_i       (abs_q),
    .clear_i     (bus.sad_clear),
    .sad_o       (sad_w),
    .sad_valid_o (sad_valid_w)
  );

  assign bus.sad_out   = sad_w;
  assign bus.sad_valid = sad_valid_w;
`else
  logic unused_sad_clear;
  assign unused_sad_clear = bus.sad_clear;
  assign bus.sad_out      = '0;
  assign bus.sad_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_me_pe_sad_cell.sv
// Bench for me_pe_sad_cell. Two cells receive identical stimulus: one with
// ACC_LEN=4 and one with ACC_LEN=16. A bench-side model predicts the outputs
// of both cells.
module tb_me_pe_sad_cell;

`ifdef ME_PE_SAD_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- driven inputs ----------------
  logic       d_wr, d_sh, d_rsel, d_cmp, d_clr;
  logic [1:0] d_csel, d_cmpsel;
  logic [7:0] d_win, d_ref0, d_ref1;

  me_pe_sad_cell_if #(.ACC_LEN(4))  if_a ();
  me_pe_sad_cell_if #(.ACC_LEN(16)) if_b ();

  assign if_a.curr_wr_en = d_wr;     assign if_b.curr_wr_en = d_wr;
  assign if_a.curr_sel = d_csel;     assign if_b.curr_sel = d_csel;
  assign if_a.curr_in = d_win;       assign if_b.curr_in = d_win;
  assign if_a.ref_shift_en = d_sh;   assign if_b.ref_shift_en = d_sh;
  assign if_a.ref_src_sel = d_rsel;  assign if_b.ref_src_sel = d_rsel;
  assign if_a.ref_in = {d_ref1, d_ref0};
  assign if_b.ref_in = {d_ref1, d_ref0};
  assign if_a.cmp_valid = d_cmp;     assign if_b.cmp_valid = d_cmp;
  assign if_a.cmp_sel = d_cmpsel;    assign if_b.cmp_sel = d_cmpsel;
  assign if_a.sad_clear = d_clr;     assign if_b.sad_clear = d_clr;

  me_pe_sad_cell #(.ACC_LEN(4))  u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  me_pe_sad_cell #(.ACC_LEN(16)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  exp_q[$];     // abs_out values
  int          exp_cyc_q[$]; // cycle in which each abs value is due
  logic [15:0] sad_q0[$], sad_q1[$];
  int          sadc_q0[$], sadc_q1[$];
  logic [15:0] last_sad_a, last_sad_b;

  // bench model state
  logic [7:0]  m_slot [4];
  logic [7:0]  m_ref, m_abs;
  logic        m_absv;
  logic [15:0] m_acc [2];
  int          m_cnt [2];
  logic [15:0] m_sad [2];
  logic        m_sadv [2];
  int          alen [2] = '{4, 16};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_slot[i] = '0;
    m_ref = '0; m_abs = '0; m_absv = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = '0; m_cnt[k] = 0; m_sad[k] = '0; m_sadv[k] = 1'b0;
    end
    exp_q.delete(); exp_cyc_q.delete();
    sad_q0.delete(); sadc_q0.delete(); sad_q1.delete(); sadc_q1.delete();
  endtask

  task automatic idle();
    d_wr = 1'b0; d_sh = 1'b0; d_cmp = 1'b0; d_clr = 1'b0;
  endtask

  task automatic check_outputs();
    chk("curr_out", if_a.curr_out, m_slot[d_csel]);
    chk("curr_out_b", if_b.curr_out, m_slot[d_csel]);
    chk("ref_out", if_a.ref_out, m_ref);
    chk("ref_out_b", if_b.ref_out, m_ref);
    chk("abs_valid", if_a.abs_valid, m_absv);
    chk("abs_valid_b", if_b.abs_valid, m_absv);
    chk("abs_hold", if_a.abs_out, m_abs);
    chk("abs_out_b", if_b.abs_out, m_abs);
    if (if_a.abs_valid) begin
      if (exp_q.size() == 0) chk("abs_spur", if_a.abs_valid, 0);
      else begin
        chk("abs_val", if_a.abs_out, exp_q.pop_front());
        chk("abs_lat", cyc, exp_cyc_q.pop_front());
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      chk("abs_miss", if_a.abs_valid, 1);
      void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front());
    end
    // instance a (ACC_LEN=4)
    if (if_a.sad_valid) begin
      last_sad_a = if_a.sad_out;
      if (sad_q0.size() == 0) chk("sad_a_spur", if_a.sad_valid, 0);
      else begin
        chk("sad_a_val", if_a.sad_out, sad_q0.pop_front());
        chk("sad_a_lat", cyc, sadc_q0.pop_front());
      end
    end else if (sadc_q0.size() > 0 && sadc_q0[0] <= cyc) begin
      chk("sad_a_miss", if_a.sad_valid, 1);
      void'(sad_q0.pop_front()); void'(sadc_q0.pop_front());
    end
    chk("sad_a_out", if_a.sad_out, m_sad[0]);
    chk("sad_a_vld", if_a.sad_valid, m_sadv[0]);
    // instance b (ACC_LEN=16)
    if (if_b.sad_valid) begin
      last_sad_b = if_b.sad_out;
      if (sad_q1.size() == 0) chk("sad_b_spur", if_b.sad_valid, 0);
      else begin
        chk("sad_b_val", if_b.sad_out, sad_q1.pop_front());
        chk("sad_b_lat", cyc, sadc_q1.pop_front());
      end
    end else if (sadc_q1.size() > 0 && sadc_q1[0] <= cyc) begin
      chk("sad_b_miss", if_b.sad_valid, 1);
      void'(sad_q1.pop_front()); void'(sadc_q1.pop_front());
    end
    chk("sad_b_out", if_b.sad_out, m_sad[1]);
    chk("sad_b_vld", if_b.sad_valid, m_sadv[1]);
  endtask

  // Applies the inputs currently driven for one clock. It pushes the
  // expected results, advances the model and checks the outputs afterwards.
  task automatic cycle();
    logic [7:0]  a, d, n_abs;
    logic        n_absv;
    logic [15:0] base_acc;
    int          base_cnt;
    // windowed sum model, fed by the abs value visible this cycle
    for (int k = 0; k < 2; k++) begin
      m_sadv[k] = 1'b0;
      if (ACC_EN) begin
        base_acc = d_clr ? 16'd0 : m_acc[k];
        base_cnt = d_clr ? 0 : m_cnt[k];
        m_acc[k] = base_acc;
        m_cnt[k] = base_cnt;
        if (m_absv) begin
          if (base_cnt == alen[k] - 1) begin
            m_sad[k] = base_acc + 16'(m_abs);
            m_sadv[k] = 1'b1;
            m_acc[k] = '0;
            m_cnt[k] = 0;
            if (k == 0) begin sad_q0.push_back(m_sad[0]); sadc_q0.push_back(cyc + 1); end
            else        begin sad_q1.push_back(m_sad[1]); sadc_q1.push_back(cyc + 1); end
          end else begin
            m_acc[k] = base_acc + 16'(m_abs);
            m_cnt[k] = base_cnt + 1;
          end
        end
      end
    end
    // compare uses the pre-edge slot and ref values
    n_absv = d_cmp;
    n_abs  = m_abs;
    if (d_cmp) begin
      a = m_slot[d_cmpsel];
      d = (a > m_ref) ? a - m_ref : m_ref - a;
      n_abs = d;
      exp_q.push_back(d);
      exp_cyc_q.push_back(cyc + 1);
    end
    if (d_sh) m_ref = d_rsel ? d_ref1 : d_ref0;
    if (d_wr) m_slot[d_csel] = d_win;
    @(posedge clk);
    cyc++;
    m_abs  = n_abs;
    m_absv = n_absv;
    @(negedge clk);
    check_outputs();
  endtask

  // Reset is asserted away from any edge and takes effect at once.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_ref", if_a.ref_out, 0);
    chk("rst_abs", if_a.abs_out, 0);
    chk("rst_absv", if_a.abs_valid, 0);
    chk("rst_sad_a", if_a.sad_out, 0);
    chk("rst_sadv_a", if_a.sad_valid, 0);
    chk("rst_sad_b", if_b.sad_out, 0);
    chk("rst_sadv_b", if_b.sad_valid, 0);
    model_reset();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
  endtask

  task automatic write_slot(input logic [1:0] s, input logic [7:0] v);
    idle(); d_wr = 1'b1; d_csel = s; d_win = v; cycle();
  endtask

  task automatic load_ref(input logic sel);
    idle(); d_sh = 1'b1; d_rsel = sel; cycle();
  endtask

  task automatic compare(input logic [1:0] s);
    idle(); d_cmp = 1'b1; d_cmpsel = s; cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    d_csel = '0; d_cmpsel = '0; d_win = '0; d_rsel = 1'b0;
    d_ref0 = '0; d_ref1 = '0;
    last_sad_a = '0; last_sad_b = '0;
    do_reset();
    cycle();

    // preload 10,20,30,40, then present slot 2 downstream
    for (int i = 0; i < 4; i++) write_slot(2'(i), 8'(10 * (i + 1)));
    idle(); d_csel = 2'd2; cycle();
    chk("preload", if_a.curr_out, 30);

    // ref mux and both operand orders
    d_ref0 = 8'd5; d_ref1 = 8'd200;
    load_ref(1'b1);
    chk("ref_sel1", if_a.ref_out, 200);
    compare(2'd0);
    chk("abs_190", if_a.abs_out, 190);
    load_ref(1'b0);
    compare(2'd3);
    chk("abs_35", if_a.abs_out, 35);

    // window of four against ref 0: 10+20+30+40
    d_ref0 = 8'd0;
    load_ref(1'b0);
    idle(); d_clr = 1'b1; cycle();
    for (int i = 0; i < 4; i++) compare(2'(i));
    idle(); cycle();
    chk("win_sum", last_sad_a, ACC_EN ? 100 : 0);
    idle(); cycle();

    // same-cycle write and compare of slot 1 sees the old value
    idle(); d_wr = 1'b1; d_csel = 2'd1; d_win = 8'd99; d_cmp = 1'b1; d_cmpsel = 2'd1; cycle();
    chk("haz_old", if_a.abs_out, 20);
    compare(2'd1);
    chk("haz_new", if_a.abs_out, 99);
    // same-cycle ref load and compare sees the old ref (0)
    d_ref1 = 8'd60;
    idle(); d_sh = 1'b1; d_rsel = 1'b1; d_cmp = 1'b1; d_cmpsel = 2'd0; cycle();
    chk("haz_ref", if_a.abs_out, 10);
    load_ref(1'b0);

    // sad_clear coincident with abs_valid = 7, then three diffs of 1
    write_slot(2'd0, 8'd3); write_slot(2'd1, 8'd4);
    write_slot(2'd2, 8'd7); write_slot(2'd3, 8'd1);
    idle(); d_clr = 1'b1; cycle();
    compare(2'd0); compare(2'd1); compare(2'd2);
    idle(); d_clr = 1'b1; d_cmp = 1'b1; d_cmpsel = 2'd3; cycle();
    compare(2'd3); compare(2'd3);
    idle(); cycle();
    chk("clr_sum", last_sad_a, ACC_EN ? 10 : 0);
    idle(); cycle();

    // worst case: every slot 255, ref 0, continuous compares
    for (int i = 0; i < 4; i++) write_slot(2'(i), 8'd255);
    idle(); d_clr = 1'b1; cycle();
    for (int i = 0; i < 32; i++) compare(2'(i % 4));
    idle(); cycle();
    chk("worst_b", last_sad_b, ACC_EN ? 4080 : 0);
    chk("worst_a", last_sad_a, ACC_EN ? 1020 : 0);
    // reset mid-window: no partial sum may come out
    for (int i = 0; i < 6; i++) compare(2'(i % 4));
    do_reset();
    for (int i = 0; i < 4; i++) begin idle(); cycle(); end

    // random traffic
    for (int i = 0; i < 300; i++) begin
      d_wr     = 1'($urandom_range(0, 1));
      d_csel   = 2'($urandom_range(0, 3));
      d_win    = 8'($urandom_range(0, 255));
      d_sh     = ($urandom_range(0, 3) == 0);
      d_rsel   = 1'($urandom_range(0, 1));
      d_ref0   = 8'($urandom_range(0, 255));
      d_ref1   = 8'($urandom_range(0, 255));
      d_cmp    = ($urandom_range(0, 3) != 0);
      d_cmpsel = 2'($urandom_range(0, 3));
      d_clr    = ($urandom_range(0, 31) == 0);
      cycle();
    end
    for (int i = 0; i < 3; i++) begin idle(); cycle(); end

    chk("abs_q_drained", exp_q.size(), 0);
    chk("sad_q_drained", sad_q0.size() + sad_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
